rv_branch_resolve: RTL

EX-stage branch resolution unit and the producer side of the 2-bit branch prediction interface. It evaluates conditional branches, JAL and JALR, and compares each outcome with the prediction carried down from ID. It emits a registered update packet for the prediction buffer, plus a redirect and flush sequence toward IF. It also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/rv_branch_resolve.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rv_branch_resolve.sv
// EX-stage branch resolution: evaluates branches/JAL/JALR, emits prediction-buffer updates and IF redirect/flush.
// Latency: every output is registered, so results appear the cycle after the instruction is accepted.
// Backpressure: EX_stall_i holds off acceptance; while flushing, all EX inputs are ignored as wrong-path.
module rv_branch_resolve #(
  parameter int XLEN      = 32,
  parameter int IDX_W     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_valid_i,
  input  logic             EX_stall_i,
  input  logic             EX_branch_i,
  input  logic             EX_jal_i,
  input  logic             EX_jalr_i,
  input  logic [2:0]       EX_funct3_i,
  input  logic [XLEN-1:0]  EX_rs1_i,
  input  logic [XLEN-1:0]  EX_rs2_i,
  input  logic [XLEN-1:0]  EX_pc_i,
  input  logic [XLEN-1:0]  EX_imm_i,
  input  logic             EX_predict_i,
  output logic             upd_branch_o,
  output logic             upd_taken_o,
  output logic [IDX_W-1:0] upd_addr_o,
  output logic             IF_redirect_o,
  output logic [XLEN-1:0]  IF_target_o,
  output logic             IF_flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Last flush-counter value before returning to IDLE; the counter starts at 1
  // in the cycle the redirect is issued, so flush stays high FLUSH_CYC cycles.
  localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q;
  logic [3:0]       flush_cnt_q;

  logic             upd_branch_q;
  logic             upd_taken_q;
  logic [IDX_W-1:0] upd_addr_q;
  logic             redirect_q;
  logic [XLEN-1:0]  target_q;
  logic             flush_q;
  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Decoded instruction class, with jalr > jal > branch priority
  logic is_jalr, is_jal, is_br;
  logic accept;

  // Direction evaluation
  logic op_eq, op_lt_s, op_lt_u;
  logic br_taken, br_legal;

  // Target arithmetic
  logic [XLEN-1:0] pc_imm_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] fall_tgt;
  logic [XLEN-1:0] redirect_tgt;

  logic need_redirect;
  logic upd_vld;
  logic mispred_vld;

  assign is_jalr = EX_jalr_i;
  assign is_jal  = EX_jal_i & ~EX_jalr_i;
  assign is_br   = EX_branch_i & ~EX_jal_i & ~EX_jalr_i;

  // Only IDLE accepts: anything arriving during FLUSH is on the squashed path.
  assign accept = EX_valid_i & ~EX_stall_i & (state_q == IDLE) &
                  (EX_branch_i | EX_jal_i | EX_jalr_i);

  assign op_eq   = (EX_rs1_i == EX_rs2_i);
  assign op_lt_s = ($signed(EX_rs1_i) < $signed(EX_rs2_i));
  assign op_lt_u = (EX_rs1_i < EX_rs2_i);

  // Resolve branch direction from funct3; 010/011 are not branches and resolve not-taken
  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (EX_funct3_i)
      3'b000:  br_taken = op_eq;
      3'b001:  br_taken = ~op_eq;
      3'b100:  br_taken = op_lt_s;
      3'b101:  br_taken = ~op_lt_s;
      3'b110:  br_taken = op_lt_u;
      3'b111:  br_taken = ~op_lt_u;
      default: begin
        br_taken = 1'b0;
        br_legal = 1'b0;
      end
    endcase
  end

  assign pc_imm_tgt = EX_pc_i + EX_imm_i;
  assign jalr_sum   = EX_rs1_i + EX_imm_i;
  assign jalr_tgt   = jalr_sum & ~XLEN'(1);
  assign fall_tgt   = EX_pc_i + XLEN'(4);

  // Jumps always redirect because the prediction buffer carries no targets.
  assign need_redirect = is_jal | is_jalr | (is_br & (br_taken != EX_predict_i));

  // Select redirect target: jump target, taken-path target, or fall-through
  always_comb begin
    redirect_tgt = fall_tgt;
    if (is_jalr) begin
      redirect_tgt = jalr_tgt;
    end else if (is_jal || br_taken) begin
      redirect_tgt = pc_imm_tgt;
    end
  end

  assign upd_vld     = accept & is_br & br_legal;
  assign mispred_vld = upd_vld & need_redirect;

  // Saturating performance counter next-state
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_vld && (branch_cnt_q != CNT_MAX)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispred_vld && (mispred_cnt_q != CNT_MAX)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Prediction-buffer update packet; direction and index hold between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_branch_q <= 1'b0;
      upd_taken_q  <= 1'b0;
      upd_addr_q   <= '0;
    end else begin
      upd_branch_q <= upd_vld;
      if (upd_vld) begin
        upd_taken_q <= br_taken;
        upd_addr_q  <= EX_pc_i[IDX_W+1:2];
      end
    end
  end

  // Redirect/flush FSM with registered redirect strobe, target and flush level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= 4'd0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
      flush_q     <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && need_redirect) begin
            state_q     <= FLUSH;
            flush_cnt_q <= 4'd1;
            redirect_q  <= 1'b1;
            target_q    <= redirect_tgt;
            flush_q     <= 1'b1;
          end
        end
        FLUSH: begin
          // Counting is independent of EX_stall_i: the squash window is fixed.
          if (flush_cnt_q >= FLUSH_LAST) begin
            state_q     <= IDLE;
            flush_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          flush_cnt_q <= 4'd0;
          flush_q     <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign upd_branch_o     = upd_branch_q;
  assign upd_taken_o      = upd_taken_q;
  assign upd_addr_o       = upd_addr_q;
  assign IF_redirect_o    = redirect_q;
  assign IF_target_o      = target_q;
  assign IF_flush_o       = flush_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispred_cnt_q;

endmodule
